// File: rtl/eth_mac_pkg.sv
// eth_mac_pkg: shared TX arbiter state encoding, arbitration modes and helpers
package eth_mac_pkg;
  typedef enum logic [1:0] {ST_IDLE, ST_PASS, ST_ABORT, ST_DRAIN} tx_state_e;
  localparam int ARB_RR   = 0;
  localparam int ARB_PRIO = 1;
  function automatic int idx_width(input int n);
    return n > 1 ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/eth_tx_rr_arbiter.sv
// eth_tx_rr_arbiter: combinational round-robin / fixed-priority grant picker
module eth_tx_rr_arbiter
  import eth_mac_pkg::*;
#(
  parameter int CHANNELS = 4,
  parameter int ARB_MODE = ARB_RR,
  parameter int IW       = idx_width(CHANNELS)
) (
  input  logic [CHANNELS-1:0] req,
  input  logic [IW-1:0]       ptr,
  output logic [CHANNELS-1:0] grant,
  output logic [IW-1:0]       index
);
  // Scan from lowest to highest precedence so the last hit wins
  always_comb begin
    grant = '0;
    index = '0;
    for (int i = CHANNELS; i >= 1; i--) begin
      if (req[IW'(ARB_MODE == ARB_PRIO ? i - 1 : (int'(ptr) + i) % CHANNELS)]) begin
        index = IW'(ARB_MODE == ARB_PRIO ? i - 1 : (int'(ptr) + i) % CHANNELS);
        grant = '0;
        grant[index] = 1'b1;
      end
    end
  end
endmodule

// File: rtl/eth_mac_tx_frame_arbiter.sv
// eth_mac_tx_frame_arbiter: frame-granular N:1 AXIS mux into the 1G MAC TX path
// with an underflow watchdog that aborts and drains a starved frame.
module eth_mac_tx_frame_arbiter
  import eth_mac_pkg::*;
#(
  parameter int CHANNELS   = 4,
  parameter int DATA_WIDTH = 8,
  parameter int ARB_MODE   = ARB_RR,
  parameter int TIMEOUT    = 16,
  parameter int CNT_WIDTH  = 5
) (
  input  logic                           tx_clk,
  input  logic                           tx_rst,
  input  logic [CHANNELS*DATA_WIDTH-1:0] s_axis_tdata,
  input  logic [CHANNELS-1:0]            s_axis_tvalid,
  output logic [CHANNELS-1:0]            s_axis_tready,
  input  logic [CHANNELS-1:0]            s_axis_tlast,
  input  logic [CHANNELS-1:0]            s_axis_tuser,
  output logic [DATA_WIDTH-1:0]          m_axis_tdata,
  output logic                           m_axis_tvalid,
  input  logic                           m_axis_tready,
  output logic                           m_axis_tlast,
  output logic                           m_axis_tuser,
  input  logic [CHANNELS-1:0]            ch_enable,
  output logic                           grant_valid,
  output logic [3:0]                     grant_index,
  output logic [CHANNELS-1:0]            stat_frame_done,
  output logic [CHANNELS-1:0]            stat_frame_abort
);
  localparam int IW = idx_width(CHANNELS);
  tx_state_e state, state_n;
  logic [IW-1:0] g, ptr, arb_index;
  logic [CHANNELS-1:0] req, g_oh, arb_grant, out_oh;
  logic [CNT_WIDTH-1:0] wd_cnt;
  logic out_abort, load_ok, g_valid, g_last, wd_hit, xfer;
  assign req     = s_axis_tvalid & ch_enable;
  assign load_ok = m_axis_tready | ~m_axis_tvalid;
  assign g_valid = s_axis_tvalid[g];
  assign g_last  = s_axis_tlast[g];
  assign wd_hit  = TIMEOUT != 0 && wd_cnt == CNT_WIDTH'(TIMEOUT);
  assign xfer    = state == ST_PASS && g_valid && load_ok && !wd_hit;
  eth_tx_rr_arbiter #(.CHANNELS(CHANNELS), .ARB_MODE(ARB_MODE), .IW(IW)) u_arb (
    .req   (req),
    .ptr   (ptr),
    .grant (arb_grant),
    .index (arb_index)
  );
  always_ff @(posedge tx_clk or posedge tx_rst) begin
    if (tx_rst) state <= ST_IDLE;
    else        state <= state_n;
  end
  always_comb begin
    state_n = state;
    case (state)
      ST_IDLE:  state_n = |req ? ST_PASS : ST_IDLE;
      ST_PASS:  state_n = xfer && g_last ? ST_IDLE : wd_hit ? ST_ABORT : ST_PASS;
      ST_ABORT: state_n = load_ok ? ST_DRAIN : ST_ABORT;
      ST_DRAIN: state_n = g_valid && g_last ? ST_IDLE : ST_DRAIN;
      default:  state_n = ST_IDLE;
    endcase
  end
  // The abort beat also ends with tlast, so done is masked by out_abort
  always_comb begin
    s_axis_tready   = g_oh & {CHANNELS{state == ST_PASS ? load_ok && !wd_hit : state == ST_DRAIN}};
    grant_valid     = state != ST_IDLE;
    grant_index     = 4'(g);
    stat_frame_done = out_oh & {CHANNELS{m_axis_tvalid && m_axis_tready && m_axis_tlast && !out_abort}};
  end
  always_ff @(posedge tx_clk or posedge tx_rst) begin
    if (tx_rst) begin
      ptr              <= IW'(CHANNELS - 1);
      g                <= '0;
      g_oh             <= '0;
      wd_cnt           <= '0;
      m_axis_tdata     <= '0;
      m_axis_tvalid    <= 1'b0;
      m_axis_tlast     <= 1'b0;
      m_axis_tuser     <= 1'b0;
      out_oh           <= '0;
      out_abort        <= 1'b0;
      stat_frame_abort <= '0;
    end else begin
      stat_frame_abort <= '0;
      if (m_axis_tready) m_axis_tvalid <= 1'b0;
      if (state == ST_IDLE && |req) begin
        g      <= arb_index;
        g_oh   <= arb_grant;
        wd_cnt <= '0;
      end
      // MAC stalls leave load_ok low, so backpressure never advances the watchdog
      if (xfer) begin
        m_axis_tdata  <= s_axis_tdata[g*DATA_WIDTH +: DATA_WIDTH];
        m_axis_tvalid <= 1'b1;
        m_axis_tlast  <= g_last;
        m_axis_tuser  <= s_axis_tuser[g];
        out_oh        <= g_oh;
        out_abort     <= 1'b0;
        wd_cnt        <= '0;
      end else if (state == ST_PASS && load_ok && !wd_hit) begin
        wd_cnt <= wd_cnt + 1'b1;
      end
      if (state == ST_ABORT && load_ok) begin
        m_axis_tdata     <= '0;
        m_axis_tvalid    <= 1'b1;
        m_axis_tlast     <= 1'b1;
        m_axis_tuser     <= 1'b1;
        out_oh           <= g_oh;
        out_abort        <= 1'b1;
        stat_frame_abort <= g_oh;
      end
      if ((xfer && g_last) || (state == ST_DRAIN && g_valid && g_last)) ptr <= g;
    end
  end
endmodule

// File: tb/tb_eth_mac_tx_frame_arbiter.sv
// tb_eth_mac_tx_frame_arbiter: randomized + directed checks against a frame-level
// model; a second fixed-priority instance runs alongside with constant traffic.
module tb_eth_mac_tx_frame_arbiter;
  import eth_mac_pkg::*;
  localparam int N = 4, DW = 8;
  logic tx_clk = 1'b0, tx_rst = 1'b1;
  always #5 tx_clk = ~tx_clk;
  logic [N*DW-1:0] s_tdata;
  logic [N-1:0] s_tvalid, s_tready, s_tlast, s_tuser, ch_enable, done, abort;
  logic [DW-1:0] m_tdata;
  logic m_tvalid, m_tready, m_tlast, m_tuser, gvalid;
  logic [3:0] gidx;
  logic [N-1:0] fp_tready, fp_done, fp_abort;
  logic [DW-1:0] fp_tdata;
  logic fp_tvalid, fp_tlast, fp_tuser, fp_gvalid;
  logic [3:0] fp_gidx;
  eth_mac_tx_frame_arbiter #(.CHANNELS(N), .DATA_WIDTH(DW), .ARB_MODE(ARB_RR), .TIMEOUT(4), .CNT_WIDTH(5)) dut (
    .tx_clk(tx_clk), .tx_rst(tx_rst),
    .s_axis_tdata(s_tdata), .s_axis_tvalid(s_tvalid), .s_axis_tready(s_tready),
    .s_axis_tlast(s_tlast), .s_axis_tuser(s_tuser),
    .m_axis_tdata(m_tdata), .m_axis_tvalid(m_tvalid), .m_axis_tready(m_tready),
    .m_axis_tlast(m_tlast), .m_axis_tuser(m_tuser),
    .ch_enable(ch_enable), .grant_valid(gvalid), .grant_index(gidx),
    .stat_frame_done(done), .stat_frame_abort(abort)
  );
  eth_mac_tx_frame_arbiter #(.CHANNELS(N), .DATA_WIDTH(DW), .ARB_MODE(ARB_PRIO), .TIMEOUT(4), .CNT_WIDTH(5)) fp_dut (
    .tx_clk(tx_clk), .tx_rst(tx_rst),
    .s_axis_tdata(32'h44332211), .s_axis_tvalid(4'b1010), .s_axis_tready(fp_tready),
    .s_axis_tlast(4'b1111), .s_axis_tuser(4'b0000),
    .m_axis_tdata(fp_tdata), .m_axis_tvalid(fp_tvalid), .m_axis_tready(1'b1),
    .m_axis_tlast(fp_tlast), .m_axis_tuser(fp_tuser),
    .ch_enable(4'b1111), .grant_valid(fp_gvalid), .grant_index(fp_gidx),
    .stat_frame_done(fp_done), .stat_frame_abort(fp_abort)
  );
  int n_chk, n_fail, fp_d1, fp_d3, m_ptr, gap_max, rdy_mode;
  int gap[N];
  int abort_cnt[N];
  bit gap_chk, prev_last;
  logic [9:0] srcq[N][$];
  logic [9:0] plq[N][$];
  logic [12:0] expq[$];
  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, act, exp, $time);
    end
  endtask
  function automatic bit busy();
    for (int c = 0; c < N; c++) if (srcq[c].size() > 0) return 1'b1;
    return 1'b0;
  endfunction
  task automatic push_frame(input int c, input int len);
    logic [9:0] b;
    for (int i = 0; i < len; i++) begin
      b = {1'($urandom), i == len - 1, 8'($urandom)};
      srcq[c].push_back(b);
      plq[c].push_back(b);
    end
  endtask
  // Whole frames leave in round-robin order among channels with pending frames
  task automatic plan(input logic [N-1:0] mask);
    logic [9:0] b;
    int k;
    bit found;
    do begin
      found = 1'b0;
      k = 0;
      for (int i = 1; i <= N; i++)
        if (!found && mask[(m_ptr + i) % N] && plq[(m_ptr + i) % N].size() > 0) begin
          k = (m_ptr + i) % N;
          found = 1'b1;
        end
      if (found) begin
        do begin
          b = plq[k].pop_front();
          expq.push_back({1'b0, 2'(k), b});
        end while (!b[8]);
        m_ptr = k;
      end
    end while (found);
  endtask
  task automatic tick();
    logic [12:0] e;
    logic [9:0] b;
    logic [N-1:0] exp_done;
    @(negedge tx_clk);
    for (int c = 0; c < N; c++) begin
      s_tvalid[c] = srcq[c].size() > 0 && gap[c] == 0;
      {s_tuser[c], s_tlast[c], s_tdata[c*DW +: DW]} = srcq[c].size() > 0 ? srcq[c][0] : 10'h0;
    end
    m_tready = rdy_mode == 0 ? $urandom_range(0, 3) != 0 : rdy_mode == 1;
    #1;
    exp_done = '0;
    if (gap_chk && prev_last) check("gap_cycle", m_tvalid, 0);
    prev_last = m_tvalid && m_tready && m_tlast;
    if (m_tvalid && m_tready) begin
      check("beat_expected", expq.size() > 0, 1);
      if (expq.size() > 0) begin
        e = expq.pop_front();
        check("tdata", m_tdata, e[7:0]);
        check("tlast", m_tlast, e[8]);
        check("tuser", m_tuser, e[9]);
        if (e[8] && !e[12]) exp_done[e[11:10]] = 1'b1;
      end
    end
    check("frame_done", done, exp_done);
    for (int c = 0; c < N; c++) begin
      abort_cnt[c] += int'(abort[c]);
      if (s_tvalid[c] && s_tready[c]) begin
        b = srcq[c].pop_front();
        gap[c] = b[8] ? 0 : $urandom_range(0, gap_max);
      end else if (gap[c] > 0) gap[c]--;
    end
    if (fp_gvalid) check("fp_grant", fp_gidx, 1);
    fp_d1 += int'(fp_done[1]);
    fp_d3 += int'(fp_done[3]);
  endtask
  task automatic drain_all(input int max);
    int t;
    t = 0;
    while (t < max && (expq.size() > 0 || busy())) begin
      tick();
      t++;
    end
    check("drain_in_time", t < max, 1);
  endtask
  initial begin
    #500000;
    $display("FAIL global_timeout");
    $fatal(1);
  end
  initial begin
    logic [9:0] b;
    logic [DW-1:0] held;
    int ab, t;
    s_tvalid = '0; s_tlast = '0; s_tuser = '0; s_tdata = '0;
    ch_enable = '1; m_tready = 1'b0;
    gap_max = 0; rdy_mode = 1; m_ptr = N - 1;
    for (int c = 0; c < N; c++) gap[c] = 0;
    #3;
    check("reset_outputs", {m_tdata, m_tvalid, m_tlast, m_tuser, gvalid, gidx, s_tready, done, abort}, 0);
    repeat (2) @(negedge tx_clk);
    tx_rst = 1'b0;
    // ch0 and ch2 together: ch0 first, one idle output cycle, then ch2
    gap_chk = 1'b1; prev_last = 1'b0;
    push_frame(0, 3);
    push_frame(2, 3);
    plan('1);
    drain_all(50);
    gap_chk = 1'b0;
    // Underflow: two beats, starve, expect a zero/tlast/tuser abort beat, then drain
    ab = abort_cnt[0];
    for (int i = 0; i < 2; i++) begin
      b = {2'b00, 8'($urandom)};
      srcq[0].push_back(b);
      expq.push_back({3'b000, b});
    end
    expq.push_back({1'b1, 2'd0, 2'b11, 8'h00});
    repeat (12) tick();
    check("abort_beat_out", expq.size(), 0);
    for (int i = 0; i < 3; i++) srcq[0].push_back({1'b0, i == 2, 8'($urandom)});
    drain_all(50);
    check("abort_pulse", abort_cnt[0] - ab, 1);
    m_ptr = 0;
    // MAC stall far beyond TIMEOUT must not abort and must hold the beat
    ab = abort_cnt[0] + abort_cnt[1] + abort_cnt[2] + abort_cnt[3];
    push_frame(1, 6);
    plan('1);
    repeat (4) tick();
    rdy_mode = 2;
    tick();
    held = m_tdata;
    repeat (20) begin
      tick();
      check("stall_hold", {m_tvalid, m_tdata}, {1'b1, held});
    end
    rdy_mode = 1;
    drain_all(50);
    check("stall_no_abort", abort_cnt[0] + abort_cnt[1] + abort_cnt[2] + abort_cnt[3] - ab, 0);
    // Disabling ch1 mid-frame finishes the frame but blocks new grants
    gap_chk = 1'b1; prev_last = 1'b0;
    push_frame(1, 4);
    plan('1);
    repeat (3) tick();
    ch_enable[1] = 1'b0;
    drain_all(40);
    push_frame(1, 3);
    plan(4'b1101);
    repeat (10) begin
      tick();
      check("disabled_idle", gvalid, 0);
    end
    check("disabled_pending", srcq[1].size(), 3);
    ch_enable = '1;
    plan('1);
    drain_all(40);
    gap_chk = 1'b0;
    // Randomized rounds with in-frame gaps and random MAC backpressure
    gap_max = 2; rdy_mode = 0;
    repeat (4) begin
      for (int c = 0; c < N; c++) repeat ($urandom_range(1, 3)) push_frame(c, $urandom_range(1, 5));
      plan('1);
      drain_all(2000);
    end
    // Reset in the middle of a ch2 frame
    gap_max = 0; rdy_mode = 1;
    push_frame(2, 6);
    plan('1);
    repeat (4) tick();
    @(negedge tx_clk);
    tx_rst = 1'b1;
    #1;
    check("reset_mid_frame", {m_tdata, m_tvalid, m_tlast, m_tuser, gvalid, gidx, s_tready, done, abort}, 0);
    for (int c = 0; c < N; c++) begin
      srcq[c].delete();
      plq[c].delete();
      gap[c] = 0;
    end
    expq.delete();
    repeat (2) tick();
    tx_rst = 1'b0;
    prev_last = 1'b0;
    m_ptr = N - 1;
    push_frame(3, 2);
    push_frame(2, 2);
    push_frame(0, 2);
    plan('1);
    t = 0;
    while (!gvalid && t < 5) begin
      tick();
      t++;
    end
    check("reset_first_grant", {gvalid, gidx}, {1'b1, 4'd0});
    drain_all(60);
    check("fp_ch1_frames", fp_d1 > 20, 1);
    check("fp_ch3_frames", fp_d3, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
